// File: rtl/ysyx_22041412_dmem_resp.sv
// Data-memory responder for the MEM stage.
// Accepts one load/store, stays busy for LATENCY cycles, then holds the
// response until the requester takes it.
module ysyx_22041412_dmem_resp #(
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wen,
  input  logic [2:0]  func3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        readyi,
  output logic [63:0] rdata,
  output logic        stall,
  output logic        readyo,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wen_q;
  logic [2:0]  func3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem_q [DEPTH];

  logic [63:0]      off_c;
  logic [2:0]       lane_c;
  logic [IDX_W-1:0] idx_c;
  logic             range_c;
  logic             misalign_c;
  logic             badcode_c;
  logic             fault_c;
  logic [63:0]      word_c;
  logic [63:0]      sh_c;
  logic [63:0]      load_c;
  logic [7:0]       size_mask_c;
  logic [7:0]       byte_en_c;
  logic [63:0]      wmask_c;
  logic [63:0]      wshift_c;
  logic [63:0]      merged_c;
  logic             commit_c;

  // Address decode, fault detection, load extraction and store merge.
  always_comb begin
    off_c      = addr_q - BASE;
    lane_c     = addr_q[2:0];
    idx_c      = off_c[IDX_W+2:3];
    range_c    = (addr_q < BASE) || (off_c >= SPAN);
    misalign_c = 1'b0;
    case (func3_q[1:0])
      2'b01:   misalign_c = addr_q[0];
      2'b10:   misalign_c = |addr_q[1:0];
      2'b11:   misalign_c = |addr_q[2:0];
      default: misalign_c = 1'b0;
    endcase
    badcode_c = wen_q ? func3_q[2] : (func3_q == 3'b111);
    fault_c   = range_c || misalign_c || badcode_c;

    word_c = mem_q[idx_c];
    sh_c   = word_c >> {lane_c, 3'b000};
    load_c = 64'd0;
    case (func3_q)
      3'b000:  load_c = {{56{sh_c[7]}},  sh_c[7:0]};
      3'b001:  load_c = {{48{sh_c[15]}}, sh_c[15:0]};
      3'b010:  load_c = {{32{sh_c[31]}}, sh_c[31:0]};
      3'b011:  load_c = sh_c;
      3'b100:  load_c = {56'd0, sh_c[7:0]};
      3'b101:  load_c = {48'd0, sh_c[15:0]};
      3'b110:  load_c = {32'd0, sh_c[31:0]};
      default: load_c = 64'd0;
    endcase

    size_mask_c = 8'h00;
    case (func3_q[1:0])
      2'b00:   size_mask_c = 8'h01;
      2'b01:   size_mask_c = 8'h03;
      2'b10:   size_mask_c = 8'h0F;
      default: size_mask_c = 8'hFF;
    endcase
    byte_en_c = size_mask_c << lane_c;
    wmask_c   = 64'd0;
    for (int i = 0; i < 8; i++) begin
      wmask_c[8*i +: 8] = {8{byte_en_c[i]}};
    end
    wshift_c = wdata_q << {lane_c, 3'b000};
    merged_c = (word_c & ~wmask_c) | (wshift_c & wmask_c);

    commit_c = (state_q == BUSY) && (cnt_q == 4'd0) && wen_q && !fault_c && !rst;
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      mem_q[idx_c] <= merged_c;
    end
  end

  // Access sequencer with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      stall   <= 1'b0;
      readyo  <= 1'b0;
      err     <= 1'b0;
      rdata   <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            wen_q   <= wen;
            func3_q <= func3;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(LATENCY - 1);
            stall   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            stall   <= 1'b0;
            readyo  <= 1'b1;
            err     <= fault_c;
            rdata   <= (fault_c || wen_q) ? 64'd0 : load_c;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (readyi) begin
            readyo  <= 1'b0;
            err     <= 1'b0;
            rdata   <= 64'd0;
            state_q <= IDLE;
          end
        end
        default: begin
          stall   <= 1'b0;
          readyo  <= 1'b0;
          err     <= 1'b0;
          rdata   <= 64'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_dmem_resp.sv
// Bench for the data-memory responder: byte-level memory model plus a
// per-cycle expected-output timeline, one compare process, directed and
// randomized accesses on a default build and a small LATENCY=1 build.
module tb_ysyx_22041412_dmem_resp;

  localparam logic [63:0] TB_BASE = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_a    [2];
  logic        en_a     [2];
  logic        wen_a    [2];
  logic [2:0]  f3_a     [2];
  logic [63:0] addr_a   [2];
  logic [63:0] wdata_a  [2];
  logic        readyi_a [2];
  logic [63:0] rdata_a  [2];
  logic        stall_a  [2];
  logic        readyo_a [2];
  logic        err_a    [2];

  logic        exp_stall [2];
  logic        exp_ready [2];
  logic        exp_err   [2];
  logic [63:0] exp_rdata [2];

  logic [7:0]  mm [2][4096];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          check_en = 1'b0;

  ysyx_22041412_dmem_resp dut0 (
    .clk(clk), .rst(rst_a[0]), .en(en_a[0]), .wen(wen_a[0]), .func3(f3_a[0]),
    .addr(addr_a[0]), .wdata(wdata_a[0]), .readyi(readyi_a[0]),
    .rdata(rdata_a[0]), .stall(stall_a[0]), .readyo(readyo_a[0]), .err(err_a[0])
  );

  ysyx_22041412_dmem_resp #(.BASE(64'h0000_0000_8000_0000), .DEPTH(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst_a[1]), .en(en_a[1]), .wen(wen_a[1]), .func3(f3_a[1]),
    .addr(addr_a[1]), .wdata(wdata_a[1]), .readyi(readyi_a[1]),
    .rdata(rdata_a[1]), .stall(stall_a[1]), .readyo(readyo_a[1]), .err(err_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned lat_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  function automatic int unsigned depth_of(input int s);
    return (s == 0) ? 512 : 4;
  endfunction

  // Fault rule: outside the window, illegal code, or not size-aligned.
  function automatic bit m_fault(input int s, input bit w, input logic [2:0] f3, input logic [63:0] a);
    int unsigned sz = 1 << f3[1:0];
    if (a < TB_BASE) return 1'b1;
    if ((a - TB_BASE) >= 64'(8 * depth_of(s))) return 1'b1;
    if (w && f3 >= 3'd4) return 1'b1;
    if (!w && f3 == 3'd7) return 1'b1;
    if ((a % 64'(sz)) != 64'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_load(input int s, input logic [2:0] f3, input logic [63:0] a);
    int unsigned sz  = 1 << f3[1:0];
    int unsigned off = 32'(a - TB_BASE);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < int'(sz); i++) v |= 64'(mm[s][off + i]) << (8 * i);
    if (f3 < 3'd3 && sz < 8 && v[8 * sz - 1]) v |= ~64'd0 << (8 * sz);
    return v;
  endfunction

  task automatic m_store(input int s, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int unsigned sz  = 1 << f3[1:0];
    int unsigned off = 32'(a - TB_BASE);
    for (int i = 0; i < int'(sz); i++) mm[s][off + i] = 8'(wd >> (8 * i));
  endtask

  task automatic chk(input string nm, input int s, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [inst %0d] got=%h expected=%h", nm, s, got, exp);
    end
  endtask

  task automatic set_exp(input int s, input logic st, input logic ry, input logic [63:0] rd, input logic er);
    exp_stall[s] = st;
    exp_ready[s] = ry;
    exp_rdata[s] = rd;
    exp_err[s]   = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_inputs(input int s);
    en_a[s]     = 1'($urandom);
    wen_a[s]    = 1'($urandom);
    f3_a[s]     = 3'($urandom);
    addr_a[s]   = {$urandom, $urandom};
    wdata_a[s]  = {$urandom, $urandom};
    readyi_a[s] = 1'($urandom);
  endtask

  // Single compare process: every cycle, both instances against the timeline.
  always @(negedge clk) begin
    if (check_en) begin
      for (int s = 0; s < 2; s++) begin
        chk("stall",  s, 64'(stall_a[s]),  64'(exp_stall[s]));
        chk("readyo", s, 64'(readyo_a[s]), 64'(exp_ready[s]));
        chk("rdata",  s, rdata_a[s],        exp_rdata[s]);
        chk("err",    s, 64'(err_a[s]),    64'(exp_err[s]));
      end
    end
  end

  // One complete access; called right after a rising edge with the DUT idle.
  task automatic access(input int s, input bit w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input int wait_n, input bit noise,
                        output logic [63:0] got, output logic gerr, output int sc, output int rc);
    logic [63:0] er;
    bit          ef;
    ef  = m_fault(s, w, f3, a);
    er  = (ef || w) ? 64'd0 : m_load(s, f3, a);
    if (!ef && w) m_store(s, f3, a, wd);
    sc  = 0;
    rc  = 0;
    got = 64'd0;
    gerr = 1'b0;
    en_a[s] = 1'b1; wen_a[s] = w; f3_a[s] = f3; addr_a[s] = a; wdata_a[s] = wd;
    readyi_a[s] = 1'($urandom);
    tick();
    en_a[s] = 1'b0;
    for (int i = 0; i < int'(lat_of(s)); i++) begin
      set_exp(s, 1'b1, 1'b0, 64'd0, 1'b0);
      if (stall_a[s]) sc++;
      if (noise) noise_inputs(s);
      tick();
    end
    for (int k = 0; k <= wait_n; k++) begin
      set_exp(s, 1'b0, 1'b1, er, ef);
      got  = rdata_a[s];
      gerr = err_a[s];
      if (stall_a[s]) sc++;
      if (readyo_a[s]) rc++;
      if (noise) noise_inputs(s);
      readyi_a[s] = (k == wait_n);
      tick();
    end
    set_exp(s, 1'b0, 1'b0, 64'd0, 1'b0);
    en_a[s] = 1'b0;
    readyi_a[s] = 1'($urandom);
    if (readyo_a[s]) rc++;
  endtask

  initial begin
    logic [63:0] got;
    logic        gerr;
    int          sc, rc;
    for (int s = 0; s < 2; s++) begin
      rst_a[s] = 1'b1; en_a[s] = 1'b0; wen_a[s] = 1'b0; f3_a[s] = 3'd0;
      addr_a[s] = 64'd0; wdata_a[s] = 64'd0; readyi_a[s] = 1'b0;
      set_exp(s, 1'b0, 1'b0, 64'd0, 1'b0);
    end
    tick();
    tick();
    check_en = 1'b1;
    tick();
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
    tick();

    // Known contents for the low region of the default build.
    for (int w = 0; w < 32; w++) begin
      access(0, 1'b1, 3'd3, TB_BASE + 64'(8 * w), {$urandom, $urandom}, 0, 1'b0, got, gerr, sc, rc);
    end

    // sd / ld round trip.
    access(0, 1'b1, 3'd3, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, 1'b0, got, gerr, sc, rc);
    chk("sd_stall_cycles", 0, 64'(sc), 64'd2);
    chk("sd_readyo_pulse", 0, 64'(rc), 64'd1);
    access(0, 1'b0, 3'd3, 64'h8000_0010, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("ld_value", 0, got, 64'h1122_3344_5566_7788);
    chk("ld_err", 0, 64'(gerr), 64'd0);
    chk("ld_stall_cycles", 0, 64'(sc), 64'd2);
    chk("ld_readyo_pulse", 0, 64'(rc), 64'd1);

    // Byte store then signed/unsigned byte loads.
    access(0, 1'b1, 3'd0, 64'h8000_0013, 64'h0000_0000_0000_00FF, 0, 1'b0, got, gerr, sc, rc);
    access(0, 1'b0, 3'd0, 64'h8000_0013, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("lb_value", 0, got, 64'hFFFF_FFFF_FFFF_FFFF);
    access(0, 1'b0, 3'd4, 64'h8000_0013, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("lbu_value", 0, got, 64'h0000_0000_0000_00FF);
    access(0, 1'b0, 3'd3, 64'h8000_0010, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("ld_after_sb", 0, got, 64'h1122_3344_FF66_7788);

    // Faults: misaligned lw, sw below the window leaves word 0 intact.
    access(0, 1'b1, 3'd3, TB_BASE, 64'hA5A5_0000_1234_5678, 0, 1'b0, got, gerr, sc, rc);
    access(0, 1'b0, 3'd2, 64'h8000_0012, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("lw_misaligned_err", 0, 64'(gerr), 64'd1);
    chk("lw_misaligned_rdata", 0, got, 64'd0);
    access(0, 1'b1, 3'd2, 64'h7FFF_FFF8, 64'hDEAD_BEEF, 0, 1'b0, got, gerr, sc, rc);
    chk("sw_below_err", 0, 64'(gerr), 64'd1);
    access(0, 1'b0, 3'd3, TB_BASE, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("word0_unchanged", 0, got, 64'hA5A5_0000_1234_5678);

    // Back-pressure with en noise during the access.
    access(0, 1'b0, 3'd3, 64'h8000_0010, 64'd0, 3, 1'b1, got, gerr, sc, rc);
    chk("wait3_readyo_cycles", 0, 64'(rc), 64'd4);
    chk("wait3_value", 0, got, 64'h1122_3344_FF66_7788);

    // Reset during the first busy cycle of a store aborts it.
    en_a[0] = 1'b1; wen_a[0] = 1'b1; f3_a[0] = 3'd3; addr_a[0] = 64'h8000_0020;
    wdata_a[0] = 64'h0BAD_0BAD_0BAD_0BAD; readyi_a[0] = 1'b1;
    tick();
    en_a[0] = 1'b0;
    set_exp(0, 1'b1, 1'b0, 64'd0, 1'b0);
    rst_a[0] = 1'b1;
    tick();
    set_exp(0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("stall_after_rst", 0, 64'(stall_a[0]), 64'd0);
    rst_a[0] = 1'b0;
    tick();
    tick();
    access(0, 1'b0, 3'd3, 64'h8000_0020, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("aborted_sd_prior", 0, got, m_load(0, 3'd3, 64'h8000_0020));

    // Reset while a response is waiting drops it.
    en_a[0] = 1'b1; wen_a[0] = 1'b0; f3_a[0] = 3'd3; addr_a[0] = 64'h8000_0008; readyi_a[0] = 1'b0;
    tick();
    en_a[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_exp(0, 1'b1, 1'b0, 64'd0, 1'b0);
      tick();
    end
    set_exp(0, 1'b0, 1'b1, m_load(0, 3'd3, 64'h8000_0008), 1'b0);
    rst_a[0] = 1'b1;
    tick();
    set_exp(0, 1'b0, 1'b0, 64'd0, 1'b0);
    rst_a[0] = 1'b0;
    tick();
    tick();

    // Top word of the window is legal, one past is not.
    access(0, 1'b1, 3'd3, TB_BASE + 64'd4088, 64'h0102_0304_0506_0708, 0, 1'b0, got, gerr, sc, rc);
    access(0, 1'b0, 3'd3, TB_BASE + 64'd4088, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("top_word_err", 0, 64'(gerr), 64'd0);
    chk("top_word_value", 0, got, 64'h0102_0304_0506_0708);
    access(0, 1'b0, 3'd3, TB_BASE + 64'd4096, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("past_top_err", 0, 64'(gerr), 64'd1);

    // Randomized accesses against the model.
    for (int n = 0; n < 300; n++) begin
      bit          w;
      logic [2:0]  f3;
      logic [63:0] a;
      int unsigned off, sz, pick;
      w    = 1'($urandom);
      f3   = 3'($urandom);
      sz   = 1 << f3[1:0];
      pick = $urandom_range(0, 9);
      if (pick == 0) begin
        a = TB_BASE - 64'($urandom_range(1, 64));
      end else if (pick == 1) begin
        a = TB_BASE + 64'd4096 + 64'($urandom_range(0, 64));
      end else begin
        off = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) off = off & ~(sz - 1);
        a = TB_BASE + 64'(off);
      end
      access(0, w, f3, a, {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom), got, gerr, sc, rc);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Single-cycle-latency, four-word build.
    access(1, 1'b1, 3'd3, TB_BASE + 64'd24, 64'hCAFE_F00D_1234_ABCD, 0, 1'b0, got, gerr, sc, rc);
    chk("lat1_stall_cycles", 1, 64'(sc), 64'd1);
    access(1, 1'b0, 3'd3, TB_BASE + 64'd24, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("lat1_top_err", 1, 64'(gerr), 64'd0);
    chk("lat1_top_value", 1, got, 64'hCAFE_F00D_1234_ABCD);
    chk("lat1_ld_stall_cycles", 1, 64'(sc), 64'd1);
    access(1, 1'b0, 3'd3, TB_BASE + 64'd32, 64'd0, 0, 1'b0, got, gerr, sc, rc);
    chk("lat1_past_top_err", 1, 64'(gerr), 64'd1);
    access(1, 1'b0, 3'd1, TB_BASE + 64'd30, 64'd0, 2, 1'b1, got, gerr, sc, rc);
    chk("lat1_lh_value", 1, got, 64'hFFFF_FFFF_FFFF_CAFE);

    tick();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
